// File: rtl/data_bus_arb.sv
// Two-master round-robin arbiter for the shared 8-bit data bus: registered grant,
// one transfer at a time, and a slave timeout that completes the transfer with an error ack.
module data_bus_arb #(
  parameter int MSB  = 7,
  parameter int AMSB = 14,
  parameter int TMO  = 7
) (
  input  logic          clk,
  input  logic          rstb,
  input  logic          setb,
  input  logic          m0_req,
  input  logic [AMSB:0] m0_addr,
  input  logic          m0_we,
  input  logic [MSB:0]  m0_wdata,
  output logic          m0_ack,
  output logic          m0_err,
  output logic [MSB:0]  m0_rdata,
  input  logic          m1_req,
  input  logic [AMSB:0] m1_addr,
  input  logic          m1_we,
  input  logic [MSB:0]  m1_wdata,
  output logic          m1_ack,
  output logic          m1_err,
  output logic [MSB:0]  m1_rdata,
  output logic          s_req,
  output logic [AMSB:0] s_addr,
  output logic          s_we,
  output logic [MSB:0]  s_wdata,
  input  logic          s_ack,
  input  logic [MSB:0]  s_rdata,
  output logic          owner,
  output logic          busy
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t       state, state_next;
  logic         gnt, gnt_next;
  logic         last, last_next;
  logic [7:0]   cnt, cnt_next;

  logic         req_g;
  logic         tmo_hit;
  logic         done;
  logic         err;
  logic [MSB:0] rdat;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state <= IDLE;
      gnt   <= 1'b0;
      last  <= 1'b1;
      cnt   <= 8'd0;
    end else begin
      state <= state_next;
      gnt   <= gnt_next;
      last  <= last_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    gnt_next   = gnt;
    last_next  = last;
    cnt_next   = cnt;
    s_req      = 1'b0;
    s_addr     = '0;
    s_we       = 1'b0;
    s_wdata    = '0;
    done       = 1'b0;
    err        = 1'b0;
    rdat       = '0;
    req_g      = gnt ? m1_req : m0_req;
    tmo_hit    = (cnt == 8'(TMO));

    case (state)
      IDLE: begin
        if (setb && (m0_req || m1_req)) begin
          // Contention goes to whoever did not win last time.
          gnt_next   = (m0_req && m1_req) ? ~last : m1_req;
          last_next  = gnt_next;
          cnt_next   = 8'd0;
          state_next = XFER;
        end
      end
      XFER: begin
        if (!setb || !req_g) begin
          // Disabled or abandoned by the master: abort silently.
          state_next = IDLE;
        end else begin
          s_addr  = gnt ? m1_addr  : m0_addr;
          s_we    = gnt ? m1_we    : m0_we;
          s_wdata = gnt ? m1_wdata : m0_wdata;
          // A late ack in the final cycle still counts as a normal completion.
          s_req   = s_ack || !tmo_hit;
          done    = s_ack || tmo_hit;
          err     = tmo_hit && !s_ack;
          rdat    = s_ack ? s_rdata : '0;
          if (done) state_next = IDLE;
          else      cnt_next   = cnt + 8'd1;
        end
      end
      default: state_next = IDLE;
    endcase

    m0_ack   = done && !gnt;
    m0_err   = err  && !gnt;
    m0_rdata = gnt ? '0 : rdat;
    m1_ack   = done && gnt;
    m1_err   = err  && gnt;
    m1_rdata = gnt ? rdat : '0;
  end

  assign owner = gnt;
  assign busy  = (state == XFER);

endmodule

// File: tb/tb_data_bus_arb.sv
// Directed bench for data_bus_arb: reset, single reads/writes, alternation,
// timeout with and without a late ack, setb abort and asynchronous reset.
module tb_data_bus_arb;
  logic        clk = 1'b0;
  logic        rstb, setb;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [14:0] m0_addr, m1_addr;
  logic [7:0]  m0_wdata, m1_wdata;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [7:0]  m0_rdata, m1_rdata;
  logic        s_req, s_we, s_ack;
  logic [14:0] s_addr;
  logic [7:0]  s_wdata, s_rdata;
  logic        owner, busy;

  int checks = 0;
  int failures = 0;

  data_bus_arb #(.MSB(7), .AMSB(14), .TMO(7)) dut (
    .clk(clk), .rstb(rstb), .setb(setb),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_we(m0_we), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_we(m1_we), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .s_req(s_req), .s_addr(s_addr), .s_we(s_we), .s_wdata(s_wdata),
    .s_ack(s_ack), .s_rdata(s_rdata), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_sreq"}, {31'd0, s_req}, 32'd0);
    chk({tag, "_swe"}, {31'd0, s_we}, 32'd0);
    chk({tag, "_saddr"}, {17'd0, s_addr}, 32'd0);
    chk({tag, "_swdata"}, {24'd0, s_wdata}, 32'd0);
    chk({tag, "_acks"}, {28'd0, m0_ack, m0_err, m1_ack, m1_err}, 32'd0);
    chk({tag, "_rdata"}, {16'd0, m0_rdata, m1_rdata}, 32'd0);
  endtask

  initial begin
    rstb = 1'b0; setb = 1'b1;
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
    s_ack = 0; s_rdata = 8'h00;

    // Reset, then 10 idle cycles
    #2;
    chk_quiet("rst");
    chk("rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rstb = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_quiet("idle");
      chk("idle_busy", {31'd0, busy}, 32'd0);
      chk("idle_owner", {31'd0, owner}, 32'd0);
    end

    // m0 read 000A, zero-wait slave
    m0_req = 1; m0_addr = 15'h000A; m0_we = 0;
    #1;
    chk("rd_sreq_idle", {31'd0, s_req}, 32'd0);
    tick();
    s_ack = 1; s_rdata = 8'hA5;
    #1;
    chk("rd_sreq", {31'd0, s_req}, 32'd1);
    chk("rd_saddr", {17'd0, s_addr}, 32'h000A);
    chk("rd_m0ack", {31'd0, m0_ack}, 32'd1);
    chk("rd_m0err", {31'd0, m0_err}, 32'd0);
    chk("rd_m0rdata", {24'd0, m0_rdata}, 32'hA5);
    chk("rd_m1rdata", {24'd0, m1_rdata}, 32'd0);
    tick();
    m0_req = 0; s_ack = 0; s_rdata = 8'h00;
    #1;
    chk("rd_busy_after", {31'd0, busy}, 32'd0);
    chk("rd_m0ack_after", {31'd0, m0_ack}, 32'd0);

    // m1 write 0003 <- 3C with one wait state
    m1_req = 1; m1_addr = 15'h0003; m1_we = 1; m1_wdata = 8'h3C;
    #1;
    chk("wr_swe_idle", {31'd0, s_we}, 32'd0);
    tick();
    chk("wr_sreq", {31'd0, s_req}, 32'd1);
    chk("wr_saddr", {17'd0, s_addr}, 32'h0003);
    chk("wr_swe", {31'd0, s_we}, 32'd1);
    chk("wr_swdata", {24'd0, s_wdata}, 32'h3C);
    chk("wr_owner", {31'd0, owner}, 32'd1);
    chk("wr_m1ack_wait", {31'd0, m1_ack}, 32'd0);
    tick();
    s_ack = 1;
    #1;
    chk("wr_m1ack", {31'd0, m1_ack}, 32'd1);
    chk("wr_m1err", {31'd0, m1_err}, 32'd0);
    chk("wr_m0ack", {31'd0, m0_ack}, 32'd0);
    tick();
    m1_req = 0; s_ack = 0;
    #1;
    chk_quiet("wr_after");
    chk("wr_busy_after", {31'd0, busy}, 32'd0);

    // Both masters requesting from reset: 0,1,0,1
    rstb = 0; #1; rstb = 1;
    m0_req = 1; m0_addr = 15'h0011; m0_we = 0;
    m1_req = 1; m1_addr = 15'h0022; m1_we = 0;
    s_ack = 1; s_rdata = 8'h77;
    for (int i = 0; i < 4; i++) begin
      logic exp_o;
      exp_o = (i % 2 == 1);
      tick();
      chk("rr_busy", {31'd0, busy}, 32'd1);
      chk("rr_owner", {31'd0, owner}, {31'd0, exp_o});
      chk("rr_saddr", {17'd0, s_addr}, exp_o ? 32'h0022 : 32'h0011);
      chk("rr_m0ack", {31'd0, m0_ack}, {31'd0, ~exp_o});
      chk("rr_m1ack", {31'd0, m1_ack}, {31'd0, exp_o});
      chk("rr_m0rdata", {24'd0, m0_rdata}, exp_o ? 32'd0 : 32'h77);
      chk("rr_m1rdata", {24'd0, m1_rdata}, exp_o ? 32'h77 : 32'd0);
      tick();
      chk("rr_turn_busy", {31'd0, busy}, 32'd0);
      chk("rr_turn_sreq", {31'd0, s_req}, 32'd0);
    end
    m0_req = 0; m1_req = 0; s_ack = 0; s_rdata = 8'h00;

    // Timeout: slave never acks
    m0_req = 1; m0_addr = 15'h0100;
    tick();
    for (int i = 1; i <= 7; i++) begin
      chk("to_sreq_wait", {31'd0, s_req}, 32'd1);
      chk("to_ack_wait", {31'd0, m0_ack}, 32'd0);
      tick();
    end
    chk("to_m0ack", {31'd0, m0_ack}, 32'd1);
    chk("to_m0err", {31'd0, m0_err}, 32'd1);
    chk("to_m0rdata", {24'd0, m0_rdata}, 32'd0);
    chk("to_sreq", {31'd0, s_req}, 32'd0);
    chk("to_busy", {31'd0, busy}, 32'd1);
    tick();
    m0_req = 0;
    #1;
    chk("to_busy_after", {31'd0, busy}, 32'd0);

    // Late ack in the final cycle completes normally
    m0_req = 1;
    tick();
    for (int i = 1; i <= 7; i++) tick();
    s_ack = 1; s_rdata = 8'h5A;
    #1;
    chk("late_m0ack", {31'd0, m0_ack}, 32'd1);
    chk("late_m0err", {31'd0, m0_err}, 32'd0);
    chk("late_m0rdata", {24'd0, m0_rdata}, 32'h5A);
    chk("late_sreq", {31'd0, s_req}, 32'd1);
    tick();
    m0_req = 0; s_ack = 0; s_rdata = 8'h00;
    #1;
    chk("late_busy_after", {31'd0, busy}, 32'd0);

    // setb dropped in 2nd XFER cycle of a stalled transfer
    m0_req = 1;
    tick();
    chk("sb_sreq1", {31'd0, s_req}, 32'd1);
    tick();
    setb = 0;
    #1;
    chk("sb_sreq", {31'd0, s_req}, 32'd0);
    chk("sb_m0ack", {31'd0, m0_ack}, 32'd0);
    chk("sb_busy_now", {31'd0, busy}, 32'd1);
    tick();
    chk("sb_busy_next", {31'd0, busy}, 32'd0);
    tick();
    chk("sb_hold_idle", {31'd0, busy}, 32'd0);
    chk_quiet("sb_quiet");

    // Asynchronous reset mid-XFER, then m0 must win contention (last=1)
    setb = 1;
    tick();
    chk("ar_busy_pre", {31'd0, busy}, 32'd1);
    chk("ar_sreq_pre", {31'd0, s_req}, 32'd1);
    #2;
    rstb = 0;
    #1;
    chk("ar_busy", {31'd0, busy}, 32'd0);
    chk("ar_owner", {31'd0, owner}, 32'd0);
    chk_quiet("ar_quiet");
    rstb = 1;
    m1_req = 1;
    s_ack = 1; s_rdata = 8'h99;
    tick();
    chk("ar_owner_next", {31'd0, owner}, 32'd0);
    chk("ar_m0ack", {31'd0, m0_ack}, 32'd1);
    chk("ar_m1ack", {31'd0, m1_ack}, 32'd0);
    tick();
    m0_req = 0; m1_req = 0; s_ack = 0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
